// File: rtl/dual_port_mem_responder.sv
// ---------------------------------------------------------------------------
// dual_port_mem_responder
//
// Responder end of the dual-port memory interface. Holds a 2**ADDR_WIDTH
// word memory with two independent read/write ports and registered read
// data. After every reset an internal sequencer walks the whole memory and
// writes a known pattern: mem[i] = i+1 for i < INIT_COUNT, 0 otherwise.
// The ports are serviced only once that pass has finished (ready=1).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   weA/weB   in   per-port write enable
//   addressA/addressB  in  per-port address (ADDR_WIDTH)
//   dataInA/dataInB    in  per-port write data (DATA_WIDTH)
//   dataOutA/dataOutB  out per-port registered read data (DATA_WIDTH)
//   ready     out  initialisation complete, ports serviced
// ---------------------------------------------------------------------------
module dual_port_mem_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int INIT_COUNT = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  weA,
  input  logic                  weB,
  input  logic [ADDR_WIDTH-1:0] addressA,
  input  logic [ADDR_WIDTH-1:0] addressB,
  input  logic [DATA_WIDTH-1:0] dataInA,
  input  logic [DATA_WIDTH-1:0] dataInB,
  output logic [DATA_WIDTH-1:0] dataOutA,
  output logic [DATA_WIDTH-1:0] dataOutB,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // One extra bit so INIT_COUNT == DEPTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] INIT_LIMIT = (ADDR_WIDTH+1)'(INIT_COUNT);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   init_wdata;
  logic [DATA_WIDTH-1:0]   dout_a_q, dout_b_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // -------------------------------------------------------------------------
  // Sequencer: next state / counter / ready
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    init_wdata = '0;
    case (state_q)
      ST_INIT: begin
        if ({1'b0, cnt_q} < INIT_LIMIT) begin
          init_wdata = DATA_WIDTH'(cnt_q) + DATA_WIDTH'(1);
        end
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        // Last address written this cycle: memory is fully initialised.
        if (cnt_q == '1) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage. A single write process keeps the array single-driven; port A's
  // write is issued last so it wins when both ports hit the same address.
  // Contents are not reset; the sequencer rewrites every word after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == ST_INIT) begin
        mem[cnt_q] <= init_wdata;
      end else begin
        if (weB) begin
          mem[addressB] <= dataInB;
        end
        if (weA) begin
          mem[addressA] <= dataInA;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered read. A writing port returns its own write data; a port that
  // only reads sees the pre-edge contents, so a cross-port write to the same
  // address becomes visible one access later.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else if (state_q == ST_RUN) begin
      dout_a_q <= weA ? dataInA : mem[addressA];
      dout_b_q <= weB ? dataInB : mem[addressB];
    end else begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end
  end

  assign dataOutA = dout_a_q;
  assign dataOutB = dout_b_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_dual_port_mem_responder
//
// Self-checking bench for dual_port_mem_responder. Each driven cycle pushes
// its expected read data (from a bench-side memory model) into a queue; the
// entry is popped and compared one edge later when the DUT presents data.
// ---------------------------------------------------------------------------
module tb_dual_port_mem_responder;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int NINIT = 5;

  logic          clk;
  logic          rst;
  logic          weA, weB;
  logic [AW-1:0] addressA, addressB;
  logic [DW-1:0] dataInA, dataInB;
  logic [DW-1:0] dataOutA, dataOutB;
  logic          ready;

  dual_port_mem_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .INIT_COUNT(NINIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .weA      (weA),
    .weB      (weB),
    .addressA (addressA),
    .addressB (addressB),
    .dataInA  (dataInA),
    .dataInB  (dataInB),
    .dataOutA (dataOutA),
    .dataOutB (dataOutB),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            n_cmp;
  int            n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = (i < NINIT) ? DW'(i + 1) : '0;
    end
  endtask

  // One serviced cycle: drive on the falling edge, queue the expectation,
  // update the model, then compare just after the next rising edge.
  task automatic do_cycle(input string tag,
                          input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                          input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    exp_t e;
    @(negedge clk);
    weA = wa; addressA = aa; dataInA = da;
    weB = wb; addressB = ab; dataInB = db;
    e.tag   = tag;
    e.exp_a = wa ? da : model_mem[aa];
    e.exp_b = wb ? db : model_mem[ab];
    exp_q.push_back(e);
    if (wb) model_mem[ab] = db;
    if (wa) model_mem[aa] = da;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.tag, "_A"}, dataOutA, e.exp_a);
    check({e.tag, "_B"}, dataOutB, e.exp_b);
    $display("txn %-10s weA=%0b A=%0d dinA=%04h weB=%0b B=%0d dinB=%04h -> outA=%04h outB=%04h",
             e.tag, wa, aa, da, wb, ab, db, dataOutA, dataOutB);
  endtask

  // Release reset and count edges until ready, with a master write pending
  // at address 0 the whole time; outputs must stay 0 throughout.
  task automatic run_init(input string tag);
    int cycles;
    int bad_out;
    cycles  = 0;
    bad_out = 0;
    @(negedge clk);
    rst = 1'b1;
    weA = 1'b1; addressA = '0; dataInA = 16'hFFFF;
    weB = 1'b1; addressB = AW'(1); dataInB = 16'hFFFF;
    while (cycles < 1200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (dataOutA !== '0 || dataOutB !== '0) bad_out++;
      if (ready === 1'b1) break;
    end
    check({tag, "_len"}, cycles, 1024);
    check({tag, "_out0"}, bad_out, 0);
    $display("txn %-10s init cycles=%0d nonzero_out_cycles=%0d", tag, cycles, bad_out);
    model_init();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    weA = 1'b0; weB = 1'b0;
    addressA = '0; addressB = '0;
    dataInA = '0; dataInB = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_outA", dataOutA, 0);
    check("rst_outB", dataOutB, 0);

    // 1: initialisation length, writes ignored
    run_init("init1");

    // 2: pattern reads
    do_cycle("rd01", 1'b0, AW'(0), 16'h0, 1'b0, AW'(1), 16'h0);
    check("lit_a0", dataOutA, 1);
    check("lit_b1", dataOutB, 2);
    do_cycle("rd45", 1'b0, AW'(4), 16'h0, 1'b0, AW'(5), 16'h0);
    check("lit_a4", dataOutA, 5);
    check("lit_b5", dataOutB, 0);
    do_cycle("rd_last", 1'b0, AW'(1023), 16'h0, 1'b0, AW'(3), 16'h0);

    // 3: write A addr0 while B reads addr0 -> B sees old value
    do_cycle("wA_rB", 1'b1, AW'(0), 16'd4, 1'b0, AW'(0), 16'h0);
    check("lit_xB_old", dataOutB, 1);
    do_cycle("rB_new", 1'b0, AW'(2), 16'h0, 1'b0, AW'(0), 16'h0);
    check("lit_xB_new", dataOutB, 4);

    // 4: write B addr513 then A reads it
    do_cycle("wB513", 1'b0, AW'(9), 16'h0, 1'b1, AW'(513), 16'd5);
    do_cycle("rA513", 1'b0, AW'(513), 16'h0, 1'b0, AW'(6), 16'h0);
    check("lit_a513", dataOutA, 5);

    // 5: dual write to addr 7 -> A wins in storage
    do_cycle("dual_w7", 1'b1, AW'(7), 16'h00AA, 1'b1, AW'(7), 16'h00BB);
    do_cycle("rd7", 1'b0, AW'(7), 16'h0, 1'b0, AW'(7), 16'h0);
    check("lit_a7", dataOutA, 16'h00AA);
    check("lit_b7", dataOutB, 16'h00AA);

    // Random traffic on a small address window to force collisions
    for (int i = 0; i < 60; i++) begin
      do_cycle("rand",
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    end

    // 6: reset mid-run
    @(negedge clk);
    rst = 1'b0;
    weA = 1'b1; addressA = AW'(0); dataInA = 16'h1234;
    @(posedge clk);
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_outA", dataOutA, 0);
    check("mid_rst_outB", dataOutB, 0);
    $display("txn %-10s ready=%0b outA=%04h outB=%04h", "mid_rst", ready, dataOutA, dataOutB);
    run_init("init2");
    do_cycle("post_rd", 1'b0, AW'(0), 16'h0, 1'b0, AW'(513), 16'h0);
    check("lit_post_a0", dataOutA, 1);
    check("lit_post_b513", dataOutB, 0);
    do_cycle("post_rd7", 1'b0, AW'(7), 16'h0, 1'b0, AW'(4), 16'h0);

    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_mem_responder.md
Name: dual_port_mem_responder

Overview:
- Responder end of the team's dual-port memory interface. Test FSMs and datapath masters drive per-port write enable, address and write data; this block holds the storage and returns registered read data.
- After every reset it runs an internal initialisation sequencer. The sequencer loads a known pattern so that master-side tests see deterministic contents.
- Sits directly under the memory test FSMs and the board-level seven-segment display path.

Parameters:
DATA_WIDTH, 16, width of each memory word and data bus
ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH (1024 words)
INIT_COUNT, 5, number of low addresses preloaded with non-zero pattern

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets)
weA  input  1  port A write enable
weB  input  1  port B write enable
addressA  input  ADDR_WIDTH  port A address
addressB  input  ADDR_WIDTH  port B address
dataInA  input  DATA_WIDTH  port A write data
dataInB  input  DATA_WIDTH  port B write data
dataOutA  output  DATA_WIDTH  port A registered read data
dataOutB  output  DATA_WIDTH  port B registered read data
ready  output  1  high when initialisation is complete and ports are serviced

Behaviour:
Reset:
- While rst==0 at a clock edge: state=INIT, init counter=0, dataOutA=dataOutB=0, ready=0.
- Memory contents are not cleared by reset itself; they are rewritten by INIT.

State machine, two states:
- INIT: each cycle, write pattern word to mem[cnt] and increment cnt.
  - Pattern: mem[i] = i+1 for i < INIT_COUNT, else 0.
  - Example: mem[0..4] = 1..5, mem[5..1023] = 0.
  - After writing address 2**ADDR_WIDTH-1, go to RUN.
  - INIT lasts exactly 1024 cycles after the first edge with rst==1. ready=1 from the following edge.
- RUN: service both ports every cycle. Stays in RUN until reset.

During INIT:
- weA/weB, addresses and data inputs are ignored; no master write lands.
- dataOutA/dataOutB are held at 0.

Read:
- Latency is 1 cycle: address presented at edge N appears on dataOut at edge N+1.
- Outputs are registered and hold until the next edge.

Same-port write:
- Write-first: a write at edge N stores dataIn.
- The same port's dataOut at edge N+1 equals the written dataIn.

Cross-port read/write collision:
- Port X writes address K while port Y reads K in the same cycle.
- Port Y returns the old contents of K; the new value is visible to Y from the next access.

Dual-write collision:
- Both ports write the same address in the same cycle: port A's data is stored and port B's is discarded.
- Each port's dataOut still reflects its own dataIn (write-first rule).

Addressing:
- Addresses are full-width; no out-of-range case exists.
- The init counter wraps only via the INIT->RUN transition, never back to 0 on its own.

Reset mid-operation:
- rst==0 in RUN or INIT aborts the current activity, drops ready at that edge and restarts INIT from address 0.
- Any writes made before the reset are overwritten by the pattern.

Test Plan:
1. Release reset; count cycles until ready=1 -> exactly 1024 cycles, dataOutA/B==0 throughout; writes attempted during INIT (weA=1, addr 0, data 16'hFFFF) have no effect.
2. After ready: read A addr0 and B addr1 -> next cycle dataOutA=1, dataOutB=2. Read B addr5 -> 0. Read A addr4 -> 5.
3. Write A addr0 data 4 while B reads addr0 -> dataOutA=4, dataOutB=1. Next cycle B reads addr0 -> 4.
4. Write B addr513 data 5, then A reads addr513 -> dataOutB=5 at the write, then dataOutA=5.
5. Both ports write addr 7 (A=16'h00AA, B=16'h00BB) -> dataOutA=00AA, dataOutB=00BB. Next-cycle read of addr7 on either port -> 00AA.
6. After scenario 3, pulse rst low for one cycle mid-run -> ready falls at that edge. Reinit takes 1024 cycles; addr0 reads 1 again and addr513 reads 0.
